ddr_port_arbiter: RTL and testbench

- Two-requester arbiter sharing the single picorv-style DDR port (valid/ready, 25-bit longword address, 32-bit data, 4-bit byte strobe) that feeds the DDR cache/MIG bridge path.
- Requester 0 is the CPU data port. Requester 1 is the video/DMA line fetcher.
- Arbitration is round-robin. Requester 1 may lock the grant for a bounded burst of back-to-back transactions.
- Sits between the SoC bus decode and the DDR bridge instance.

---
 rtl/ddr_port_arbiter.sv | 139 +++++++++++++
 tb/tb_ddr_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one valid/ready DDR port between the CPU data port (m0)
// and the video/DMA line fetcher (m1). m1 may lock the grant for a bounded burst.
module ddr_port_arbiter #(
  parameter int ADDR_WIDTH = 25,
  parameter int MAX_BURST  = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  input  logic                  m0_valid,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  input  logic                  m1_valid,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,
  input  logic                  m1_lock,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  input  logic [31:0]           mem_rdata,
  output logic [1:0]            grant
);

  // Handshake: a requester holds valid and its payload stable until it sees its ready;
  // a transfer completes in the cycle where mem_valid and mem_ready are both high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BURST);

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 m1_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Read data is broadcast; only the per-requester ready qualifies it.
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  // Saturating increment: the counter never exceeds MAX_BURST.
  assign cnt_inc = (burst_cnt_q >= MAX_CNT) ? MAX_CNT : burst_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    mem_valid   = 1'b0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    grant       = 2'b00;
    m1_done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_valid) begin
          state_d = GNT0;
        end else if (m1_valid) begin
          state_d = GNT1;
        end
      end

      GNT0: begin
        grant     = 2'b01;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_wstrb = m0_wstrb;
        mem_valid = m0_valid;
        m0_ready  = mem_ready & m0_valid;
        if (!m0_valid) begin
          state_d = IDLE;
        end else if (mem_ready) begin
          last_d  = 1'b0;
          state_d = IDLE;
        end
      end

      GNT1: begin
        grant     = 2'b10;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_wstrb = m1_wstrb;
        mem_valid = m1_valid;
        m1_done   = mem_ready & m1_valid;
        m1_ready  = m1_done;
        if (m1_done) begin
          last_d = 1'b1;
          // Yield once the burst budget is spent and the CPU is waiting.
          if (m1_lock && !((cnt_inc >= MAX_CNT) && m0_valid)) begin
            burst_cnt_d = cnt_inc;
          end else begin
            burst_cnt_d = '0;
            state_d     = IDLE;
          end
        end else if (!m1_valid) begin
          if (!m1_lock || ((burst_cnt_q >= MAX_CNT) && m0_valid)) begin
            burst_cnt_d = '0;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: hand-computed grant sequences, datapath muxing,
// burst locking/yield, async reset and gap handling.
module tb_ddr_port_arbiter;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic          m0_valid, m1_valid, m1_lock;
  logic          m0_ready, m1_ready;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_valid, mem_ready;
  logic [31:0]   mem_rdata;
  logic [1:0]    grant;

  logic          auto_resp;
  logic          man_ready;
  logic [31:0]   man_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Downstream model: either an always-ready port or manually driven ready/rdata.
  assign mem_ready = auto_resp ? mem_valid : man_ready;
  assign mem_rdata = auto_resp ? (32'hC0DE0000 | {7'b0, mem_addr}) : man_rdata;

  ddr_port_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .m1_lock(m1_lock),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0; m0_valid = 1'b0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = '0; m1_valid = 1'b0;
    m1_lock = 1'b0; auto_resp = 1'b0; man_ready = 1'b0; man_rdata = '0;
  endtask

  // Leaves the bench at posedge+1 of "cycle 0" with reset released.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_seq [8];
  int bad, n1, m0_cyc, g9;
  bit seen;

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_readies", {30'd0, m1_ready, m0_ready}, 32'd0);
    next_cycle();
    rst = 1'b0;

    // Single m0 read with manual completion
    m0_addr = 25'h000100; m0_wstrb = 4'd0; m0_valid = 1'b1;
    @(negedge clk);
    check("t1_arb_grant", 32'(grant), 32'd0);
    check("t1_arb_valid", 32'(mem_valid), 32'd0);
    next_cycle();
    man_ready = 1'b1; man_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_grant", 32'(grant), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'h100);
    check("t1_mem_valid", 32'(mem_valid), 32'd1);
    check("t1_m0_ready", 32'(m0_ready), 32'd1);
    check("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_m1_ready", 32'(m1_ready), 32'd0);
    next_cycle();
    m0_valid = 1'b0; man_ready = 1'b0;
    @(negedge clk);
    check("t1_grant_after", 32'(grant), 32'd0);
    check("t1_m0_ready_after", 32'(m0_ready), 32'd0);

    // Round-robin alternation, both always requesting, 1-cycle downstream
    do_reset();
    auto_resp = 1'b1;
    m0_addr = 25'h000010; m1_addr = 25'h000020;
    m0_valid = 1'b1; m1_valid = 1'b1;
    exp_seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("t2_grant_c%0d", i), 32'(grant), 32'(exp_seq[i]));
      next_cycle();
    end

    // Locked m1 burst of 20 with m0 idle: no bubbles
    do_reset();
    auto_resp = 1'b1; m1_lock = 1'b1; m1_valid = 1'b1; m1_addr = 25'h0ABCDE;
    @(negedge clk);
    check("t3_arb_grant", 32'(grant), 32'd0);
    next_cycle();
    bad = 0; n1 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant !== 2'b10) bad++;
      if (m1_ready === 1'b1) n1++;
      next_cycle();
    end
    check("t3_hold_bad_cycles", 32'(bad), 32'd0);
    check("t3_completions", 32'(n1), 32'd20);
    m1_valid = 1'b0; m1_lock = 1'b0;
    @(negedge clk);
    check("t3_tail_grant", 32'(grant), 32'd2);
    check("t3_tail_valid", 32'(mem_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t3_release", 32'(grant), 32'd0);

    // Locked m1 with m0 waiting: yield after exactly 8
    do_reset();
    auto_resp = 1'b1; m1_lock = 1'b1; m1_valid = 1'b1; m1_addr = 25'h000400;
    m0_addr = 25'h000500;
    next_cycle();
    m0_valid = 1'b1;
    n1 = 0; seen = 1'b0; m0_cyc = -1; g9 = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (!seen && m1_ready === 1'b1) n1++;
      if (!seen && m0_ready === 1'b1) begin
        seen = 1'b1;
        m0_cyc = cyc;
      end
      if (cyc == 9) g9 = int'(grant);
      next_cycle();
    end
    check("t4_m0_served", 32'(seen), 32'd1);
    check("t4_m1_before_m0", 32'(n1), 32'd8);
    check("t4_m0_cycle", 32'(m0_cyc), 32'd10);
    check("t4_idle_gap", 32'(g9), 32'd0);

    // Async reset mid-GNT1
    do_reset();
    m1_valid = 1'b1; m1_addr = 25'h000777;
    next_cycle();
    man_ready = 1'b1;
    #1;
    check("t5_pre_m1_ready", 32'(m1_ready), 32'd1);
    check("t5_pre_valid", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_async_valid", 32'(mem_valid), 32'd0);
    check("t5_async_grant", 32'(grant), 32'd0);
    check("t5_async_m1_ready", 32'(m1_ready), 32'd0);
    man_ready = 1'b0; m0_valid = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("t5_arb_grant", 32'(grant), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t5_tie_m0", 32'(grant), 32'd1);

    // m1 byte write, unlocked
    do_reset();
    m1_addr = 25'h1ABCDE; m1_wdata = 32'h0000AB00; m1_wstrb = 4'b0010; m1_valid = 1'b1;
    @(negedge clk);
    check("t6_idle_wdata", mem_wdata, 32'd0);
    next_cycle();
    @(negedge clk);
    check("t6_grant", 32'(grant), 32'd2);
    check("t6_wstrb", 32'(mem_wstrb), 32'b0010);
    check("t6_wdata", mem_wdata, 32'h0000AB00);
    check("t6_addr", 32'(mem_addr), 32'h1ABCDE);
    next_cycle();
    man_ready = 1'b1;
    @(negedge clk);
    check("t6_m1_ready", 32'(m1_ready), 32'd1);
    check("t6_m0_ready", 32'(m0_ready), 32'd0);
    next_cycle();
    m1_valid = 1'b0; man_ready = 1'b0;
    @(negedge clk);
    check("t6_release", 32'(grant), 32'd0);

    // Locked gap: stray mem_ready ignored, hold below budget, release on unlock
    do_reset();
    m1_lock = 1'b1; m1_valid = 1'b1;
    next_cycle();
    m1_valid = 1'b0; man_ready = 1'b1;
    @(negedge clk);
    check("t7_gap_valid", 32'(mem_valid), 32'd0);
    check("t7_gap_ready", 32'(m1_ready), 32'd0);
    next_cycle();
    m0_valid = 1'b1;
    @(negedge clk);
    check("t7_hold_a", 32'(grant), 32'd2);
    next_cycle();
    @(negedge clk);
    check("t7_hold_b", 32'(grant), 32'd2);
    next_cycle();
    m1_lock = 1'b0;
    @(negedge clk);
    check("t7_unlock_same", 32'(grant), 32'd2);
    next_cycle();
    @(negedge clk);
    check("t7_unlock_idle", 32'(grant), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t7_m0_grant", 32'(grant), 32'd1);
    check("t7_m0_ready", 32'(m0_ready), 32'd1);
    next_cycle();
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
